// File: rtl/async_fifo_pkg.sv
// Shared constants and elaboration helpers for the single-clock byte FIFO.
// Imported by the interface, the storage array and the FIFO top.
package async_fifo_pkg;

    localparam int DEFAULT_DEPTH = 16;
    localparam int DEFAULT_WIDTH = 8;

    // Ceiling log2, evaluated at elaboration to size and sanity-check pointers.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/async_fifo_if.sv
// Producer/consumer handshake bundle for async_fifo.
// The FIFO takes the slave side; the logic feeding and draining it takes master.
interface async_fifo_if
    import async_fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] wdata_i;
    logic             wr_en_i;
    logic             full_o;
    logic             wr_error_o;
    logic [WIDTH-1:0] rdata_o;
    logic             rd_en_i;
    logic             empty_o;
    logic             rd_error_o;

    modport master (
        output wdata_i, wr_en_i, rd_en_i,
        input  full_o, empty_o, rdata_o, wr_error_o, rd_error_o
    );

    modport slave (
        input  wdata_i, wr_en_i, rd_en_i,
        output full_o, empty_o, rdata_o, wr_error_o, rd_error_o
    );

endinterface

// File: rtl/async_fifo_mem.sv
// DEPTH x WIDTH storage array for async_fifo.
// Synchronous write port and a combinational read port; the FIFO registers the read data.
module fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = clog2(DEFAULT_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [WIDTH-1:0]      i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // NOTE: storage carries no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with registered read data, full/empty status and
// one-cycle overflow/underflow error pulses. Pointers carry an extra wrap bit.
module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int PTR_WIDTH = clog2(DEFAULT_DEPTH)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    async_fifo_if.slave  bus
);

    if (PTR_WIDTH != clog2(DEPTH) || DEPTH != (1 << PTR_WIDTH)) begin : g_bad_params
        $error("async_fifo: DEPTH must be a power of two and PTR_WIDTH must equal clog2(DEPTH)");
    end

    localparam logic [PTR_WIDTH:0] PTR_ONE = 1;

    logic [PTR_WIDTH:0] r_wr_ptr;
    logic [PTR_WIDTH:0] r_rd_ptr;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_wr_error;
    logic               r_rd_error;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_accept;
    logic               w_rd_accept;
    logic [WIDTH-1:0]   w_mem_rdata;

    // Same low bits with opposite wrap bits means the writer is a full lap ahead.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_WIDTH] != r_rd_ptr[PTR_WIDTH]) &&
                     (r_wr_ptr[PTR_WIDTH-1:0] == r_rd_ptr[PTR_WIDTH-1:0]);

    assign w_wr_accept = bus.wr_en_i && !w_full;
    assign w_rd_accept = bus.rd_en_i && !w_empty;

    fifo_mem #(
        .DEPTH      (DEPTH),
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (PTR_WIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .i_we    (w_wr_accept),
        .i_waddr (r_wr_ptr[PTR_WIDTH-1:0]),
        .i_wdata (bus.wdata_i),
        .i_raddr (r_rd_ptr[PTR_WIDTH-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // NOTE: non-blocking assignments, so every update below is qualified by pre-edge flags.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rdata    <= '0;
            r_wr_error <= 1'b0;
            r_rd_error <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_rdata  <= w_mem_rdata;
            end
            r_wr_error <= bus.wr_en_i && w_full;
            r_rd_error <= bus.rd_en_i && w_empty;
        end
    end

    assign bus.full_o     = w_full;
    assign bus.empty_o    = w_empty;
    assign bus.rdata_o    = r_rdata;
    assign bus.wr_error_o = r_wr_error;
    assign bus.rd_error_o = r_rd_error;

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo: a queue-based reference model predicts the
// post-edge state of every cycle, and a monitor compares it after each rising edge.
module tb_async_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    typedef struct {
        logic             full;
        logic             empty;
        logic             wr_err;
        logic             rd_err;
        logic [WIDTH-1:0] rdata;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i;

    async_fifo_if #(.WIDTH(WIDTH)) bus ();

    async_fifo #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .PTR_WIDTH (4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] model_rdata = '0;
    exp_t             exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // One clock of stimulus: apply inputs at the falling edge and predict the
    // state the DUT must show after the following rising edge.
    task automatic drive(input logic rst, input logic wr, input logic rd,
                         input logic [WIDTH-1:0] d);
        exp_t e;
        logic was_running;
        bit   pre_full;
        bit   pre_empty;
        @(negedge clk_i);
        was_running  = rst_i;
        rst_i        = rst;
        bus.wr_en_i  = wr;
        bus.rd_en_i  = rd;
        bus.wdata_i  = d;
        if (!rst) begin
            model_q.delete();
            model_rdata = '0;
            e.wr_err = 1'b0;
            e.rd_err = 1'b0;
            if (was_running === 1'b1) begin
                #1;
                check("async_reset_empty", 32'(bus.empty_o), 32'd1);
                check("async_reset_full", 32'(bus.full_o), 32'd0);
                check("async_reset_rdata", 32'(bus.rdata_o), 32'd0);
            end
        end else begin
            pre_full  = (model_q.size() == DEPTH);
            pre_empty = (model_q.size() == 0);
            e.wr_err  = wr && pre_full;
            e.rd_err  = rd && pre_empty;
            if (rd && !pre_empty) model_rdata = model_q.pop_front();
            if (wr && !pre_full) model_q.push_back(d);
        end
        e.full  = (model_q.size() == DEPTH);
        e.empty = (model_q.size() == 0);
        e.rdata = model_rdata;
        exp_q.push_back(e);
    endtask

    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("full_o", 32'(bus.full_o), 32'(e.full));
            check("empty_o", 32'(bus.empty_o), 32'(e.empty));
            check("wr_error_o", 32'(bus.wr_error_o), 32'(e.wr_err));
            check("rd_error_o", 32'(bus.rd_error_o), 32'(e.rd_err));
            check("rdata_o", 32'(bus.rdata_o), 32'(e.rdata));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] pattern;
        rst_i       = 1'b0;
        bus.wr_en_i = 1'b0;
        bus.rd_en_i = 1'b0;
        bus.wdata_i = '0;

        repeat (2) drive(1'b0, 1'b0, 1'b0, '0);

        // Fill, overflow by one, then drain past empty by one.
        repeat (DEPTH) drive(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        drive(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        drive(1'b1, 1'b0, 1'b0, '0);
        repeat (DEPTH) drive(1'b1, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 1'b1, '0);
        drive(1'b1, 1'b0, 1'b0, '0);

        // Read and write together while empty and while full.
        drive(1'b1, 1'b1, 1'b1, 8'hA5);
        repeat (DEPTH - 1) drive(1'b1, 1'b1, 1'b0, WIDTH'($urandom));
        drive(1'b1, 1'b1, 1'b1, 8'h5A);
        repeat (DEPTH) drive(1'b1, 1'b0, 1'b1, '0);

        // Steady half-full streaming across several pointer wraps, then reset mid-stream.
        pattern = '0;
        repeat (8) begin
            drive(1'b1, 1'b1, 1'b0, pattern);
            pattern++;
        end
        repeat (40) begin
            drive(1'b1, 1'b1, 1'b1, pattern);
            pattern++;
        end
        drive(1'b0, 1'b1, 1'b1, pattern);
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, 1'b1, '0);

        // Randomized traffic with shifting bias so both full and empty are revisited.
        for (int seg = 0; seg < 6; seg++) begin
            int wr_pct;
            wr_pct = (seg % 2 == 0) ? 75 : 25;
            repeat (60) begin
                drive(1'b1,
                      ($urandom_range(0, 99) < wr_pct),
                      ($urandom_range(0, 99) < (100 - wr_pct)),
                      WIDTH'($urandom));
            end
        end

        drive(1'b1, 1'b0, 1'b0, '0);
        @(negedge clk_i);
        @(negedge clk_i);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
